// File: rtl/cas_player.sv
// Cassette FSK player: replays queued tape bytes as a square wave into the PIA
// cassette input, LSB first, one full cycle of 1200 Hz per '0' and 2400 Hz per '1'.
module cas_player #(
   parameter int HALF0 = 23863,
   parameter int HALF1 = 11932
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       motor,
   input  logic       flush,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       cas_out,
   output logic       busy,
   output logic       underrun,
   output logic [2:0] fifo_count
);
   localparam int HMAX = (HALF0 > HALF1) ? HALF0 : HALF1;
   localparam int CW   = (HMAX > 1) ? $clog2(HMAX) : 1;
   localparam logic [CW-1:0] LD0 = CW'(HALF0 - 1);
   localparam logic [CW-1:0] LD1 = CW'(HALF1 - 1);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t        state;
   logic [7:0]    fifo_mem [4];
   logic [1:0]    wr_ptr, rd_ptr;
   logic [7:0]    shreg;
   logic [2:0]    bit_idx;
   logic [CW-1:0] cnt;
   logic          push, pop, last_half, fifo_nempty, halt;
   logic [7:0]    head;

   assign in_ready    = (fifo_count < 3'd4) && !flush;
   assign push        = in_valid && in_ready;
   assign fifo_nempty = (fifo_count != 3'd0);
   assign head        = fifo_mem[rd_ptr];
   assign last_half   = (cnt == '0);
   // Motor dropping mid-byte abandons the byte but keeps the queue intact.
   assign halt        = flush || (state != IDLE && !motor);
   // Pop only from IDLE or exactly at the end of bit 7, so bytes run back to back.
   assign pop         = !halt && motor && fifo_nempty &&
                        ((state == IDLE) || (state == LOW && last_half && bit_idx == 3'd7));

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 3'd1;
            2'b01:   fifo_count <= fifo_count - 3'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_idx  <= '0;
         cnt      <= '0;
         cas_out  <= 1'b0;
         busy     <= 1'b0;
         underrun <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (halt) begin
            state   <= IDLE;
            cas_out <= 1'b0;
            busy    <= 1'b0;
         end else if (pop) begin
            shreg   <= head;
            bit_idx <= '0;
            cnt     <= head[0] ? LD1 : LD0;
            state   <= HIGH;
            cas_out <= 1'b1;
            busy    <= 1'b1;
         end else begin
            case (state)
               HIGH: begin
                  if (last_half) begin
                     state   <= LOW;
                     cas_out <= 1'b0;
                     cnt     <= shreg[0] ? LD1 : LD0;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               LOW: begin
                  if (last_half && bit_idx != 3'd7) begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= shreg >> 1;
                     cnt     <= shreg[1] ? LD1 : LD0;
                     state   <= HIGH;
                     cas_out <= 1'b1;
                  end else if (last_half) begin
                     // Motor is known high here, so no pop means the queue ran dry.
                     state    <= IDLE;
                     cas_out  <= 1'b0;
                     busy     <= 1'b0;
                     underrun <= !fifo_nempty;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               default: begin
                  state   <= IDLE;
                  cas_out <= 1'b0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/cas_player.md
CAS_PLAYER -- requirements
Module: cas_player

Interface
REQ-001 Parameter HALF0, default 23863, is the number of clk cycles per half-period of a '0' bit (1200 Hz at 57.272 MHz).
REQ-002 Parameter HALF1, default 11932, is the number of clk cycles per half-period of a '1' bit (2400 Hz at 57.272 MHz).
REQ-003 Port clk, input, 1 bit: system clock (57.272 MHz); all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port motor, input, 1 bit: cassette motor relay (PIA1 CA2); 1 = tape running.
REQ-006 Port flush, input, 1 bit: synchronous clear of the FIFO and the current byte.
REQ-007 Port in_data, input, 8 bits: tape byte from the download stream.
REQ-008 Port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-009 Port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-010 Port cas_out, output, 1 bit: FSK comparator level to PIA1 PA0 (cassette data in).
REQ-011 Port busy, output, 1 bit: a byte is being shifted out.
REQ-012 Port underrun, output, 1 bit: one-cycle pulse when a byte finishes and the FIFO is empty.
REQ-013 Port fifo_count, output, 3 bits: FIFO occupancy, range 0..4.

Function
REQ-014 Use a 4-entry byte FIFO; a push occurs when in_valid=1 and in_ready=1.
REQ-015 in_ready = (fifo_count<4) and flush=0; push and pop in the same cycle leave fifo_count unchanged.
REQ-016 States: IDLE, HIGH, LOW. Hold a shift register (8 b), a bit index (3 b), and a half-period counter sized for max(HALF0,HALF1).
REQ-017 IDLE: cas_out=0, busy=0; when motor=1 and fifo_count>0, pop the head byte and enter HIGH on the next cycle, with bit index 0 and the counter loaded for bit 0.
REQ-018 Bits go out LSB first; the half-period is HALF1 for bit value 1 and HALF0 for bit value 0.
REQ-019 HIGH: cas_out=1 for exactly HALF cycles, then go to LOW with the counter reloaded for the same bit.
REQ-020 LOW: cas_out=0 for exactly HALF cycles; then, if bit index<7, increment it, shift, and go to HIGH.
REQ-021 At the end of LOW for bit 7: if motor=1 and fifo_count>0, pop and go straight to HIGH for bit 0 of the next byte, with no gap cycle.
REQ-022 At the end of LOW for bit 7 otherwise: go to IDLE; pulse underrun for 1 cycle if fifo_count=0.
REQ-023 Each byte therefore occupies exactly the sum over its bits of 2*HALF(bit) cycles.
REQ-024 busy=1 in HIGH and LOW.
REQ-025 motor falling while in HIGH or LOW: next cycle state=IDLE and cas_out=0; the current byte is discarded; the FIFO is retained; no underrun pulse.
REQ-026 flush=1: next cycle FIFO empty, state=IDLE, cas_out=0; any push in that cycle is ignored (in_ready=0); flush has priority over motor and push.
REQ-027 Pushes are accepted in any state, including while motor=0.

Reset
REQ-028 reset=0 asynchronously forces state=IDLE, FIFO empty (fifo_count=0), cas_out=0, busy=0, underrun=0, and clears the counters and shift register.
REQ-029 After reset release, in_ready=1 on the first clock.
REQ-030 Reset mid-byte discards all data.

Verification (HALF0=6, HALF1=3)
REQ-031 Push 0x01 with motor=1 -> cas_out pattern 111000, then 7x(111111000000); busy for 90 cycles; underrun pulse at the end.
REQ-032 Push 0xFF,0x00 back-to-back -> 48 cycles of 3-cycle alternation, then 96 cycles of 6-cycle alternation, with no gap between bytes; one underrun after the second byte.
REQ-033 Push 5 bytes with motor=0 -> fifo_count=4 and in_ready=0 with the 5th held off; motor=1 -> the first pop occurs and in_ready returns to 1.
REQ-034 Drop motor mid-bit 3 of 0xAA -> cas_out=0 and IDLE next cycle; on motor=1 the next FIFO byte starts from bit 0.
REQ-035 Assert flush with 3 bytes queued mid-byte -> fifo_count=0, IDLE, cas_out=0 next cycle; in_valid in the flush cycle is not accepted.
REQ-036 Assert reset asynchronously mid-LOW -> outputs reach their reset values before the next clk edge.
